// File: rtl/teclado_rgb.sv
// teclado_rgb: 4x4 keypad scanner with debounce and key decoding. It feeds a
// digit-assembly stage (digit code, shift command, capture strobe) and the
// colour-entry path (enter pulse, R/G/B channel select).
module teclado_rgb #(
    parameter int SCAN_DIV  = 5000,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [4:0] digito,
    output logic [1:0] desp,
    output logic       pulso,
    output logic       listo,
    output logic [1:0] canal
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_SCANS);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);

    // Internal key values: digits 0-9, then letters and symbols.
    localparam logic [3:0] K_A    = 4'd10;
    localparam logic [3:0] K_B    = 4'd11;
    localparam logic [3:0] K_C    = 4'd12;
    localparam logic [3:0] K_D    = 4'd13;
    localparam logic [3:0] K_STAR = 4'd14;
    localparam logic [3:0] K_HASH = 4'd15;
    localparam logic [4:0] BLANK  = 5'd16;

    typedef enum logic [2:0] {IDLE, PRESS, EMIT, HELD, RELEASE} state_t;

    // Map bit index (4*row+col) to the legend printed on the keypad.
    function automatic logic [3:0] key_value(input logic [3:0] idx);
        case (idx)
            4'd0:    key_value = 4'd1;
            4'd1:    key_value = 4'd2;
            4'd2:    key_value = 4'd3;
            4'd3:    key_value = K_A;
            4'd4:    key_value = 4'd4;
            4'd5:    key_value = 4'd5;
            4'd6:    key_value = 4'd6;
            4'd7:    key_value = K_B;
            4'd8:    key_value = 4'd7;
            4'd9:    key_value = 4'd8;
            4'd10:   key_value = 4'd9;
            4'd11:   key_value = K_C;
            4'd12:   key_value = K_STAR;
            4'd13:   key_value = 4'd0;
            4'd14:   key_value = K_HASH;
            default: key_value = K_D;
        endcase
    endfunction

    logic [SW-1:0] slot;
    logic [1:0]    col;
    logic [15:0]   map_acc, map_now, scan_map;
    logic          scan_valid;
    logic          slot_end;

    state_t        state, state_next;
    logic [DW-1:0] deb, deb_next, deb_inc;
    logic [3:0]    key, key_next, scan_idx, kv;
    logic          armado, armado_next;
    logic          scan_none, scan_single;
    logic [2:0]    cnt;

    assign slot_end = (slot == SLOT_LAST);
    assign columnas = ~(4'b0001 << col);

    // Merge the rows read in the current column into the scan map.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        map_now = map_acc;
        map_now[{2'd0, col}] = ~filas[0];
        map_now[{2'd1, col}] = ~filas[1];
        map_now[{2'd2, col}] = ~filas[2];
        map_now[{2'd3, col}] = ~filas[3];
    end

    // Column rotation, slot timing and full-scan capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= '0;
            col        <= 2'd0;
            map_acc    <= '0;
            scan_map   <= '0;
            scan_valid <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every register sees pre-edge values, whatever the statement order.
            scan_valid <= 1'b0;
            if (slot_end) begin
                slot    <= '0;
                col     <= col + 2'd1;
                map_acc <= map_now;
                if (col == 2'd3) begin
                    scan_map   <= map_now;
                    scan_valid <= 1'b1;
                end
            end else begin
                slot <= slot + SW'(1);
            end
        end
    end

    // Classify the completed scan and locate the single pressed key.
    always_comb begin
        scan_none   = (scan_map == 16'd0);
        scan_single = $onehot(scan_map);
        scan_idx    = 4'd0;
        for (logic [4:0] i = 5'd0; i < 5'd16; i++) begin
            if (scan_map[i[3:0]]) scan_idx = i[3:0];
        end
    end

    assign deb_inc = deb + DEB_ONE;
    assign kv      = key_value(key);

    // Debounce FSM state register. armado stays low after reset until one
    // empty scan is seen, so a key held through reset never emits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            deb    <= '0;
            key    <= 4'd0;
            armado <= 1'b0;
        end else begin
            state  <= state_next;
            deb    <= deb_next;
            key    <= key_next;
            armado <= armado_next;
        end
    end

    // Debounce FSM next-state logic, evaluated once per completed scan.
    always_comb begin
        state_next  = state;
        deb_next    = deb;
        key_next    = key;
        armado_next = armado;
        case (state)
            IDLE: if (scan_valid) begin
                if (scan_none) begin
                    armado_next = 1'b1;
                end else if (scan_single && armado) begin
                    key_next   = scan_idx;
                    deb_next   = DEB_ONE;
                    state_next = (DEB_SCANS == 1) ? EMIT : PRESS;
                end
            end
            PRESS: if (scan_valid) begin
                if (scan_single && scan_idx == key) begin
                    if (deb_inc == DEB_MAX) state_next = EMIT;
                    else                    deb_next   = deb_inc;
                end else begin
                    state_next = IDLE;
                end
            end
            EMIT: state_next = HELD;
            HELD: if (scan_valid && scan_none) begin
                deb_next   = DEB_ONE;
                state_next = (DEB_SCANS == 1) ? IDLE : RELEASE;
            end
            RELEASE: if (scan_valid) begin
                if (scan_none) begin
                    if (deb_inc == DEB_MAX) state_next = IDLE;
                    else                    deb_next   = deb_inc;
                end else begin
                    state_next = HELD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Key actions: registered during EMIT, strobes high for the following clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digito <= BLANK;
            desp   <= 2'b00;
            pulso  <= 1'b0;
            listo  <= 1'b0;
            canal  <= 2'b00;
            cnt    <= 3'd0;
        end else begin
            pulso <= 1'b0;
            listo <= 1'b0;
            if (state == EMIT) begin
                case (kv)
                    K_STAR: begin
                        digito <= BLANK;
                        desp   <= 2'b00;
                        cnt    <= 3'd0;
                        pulso  <= 1'b1;
                    end
                    K_HASH: if (cnt != 3'd0 && cnt != 3'd4) begin
                        listo <= 1'b1;
                        cnt   <= 3'd0;
                    end
                    K_A, K_B, K_C: begin
                        canal  <= 2'(kv - K_A);
                        digito <= BLANK;
                        desp   <= 2'b00;
                        cnt    <= 3'd0;
                        pulso  <= 1'b1;
                    end
                    K_D: ;
                    default: begin
                        digito <= {1'b0, kv};
                        pulso  <= 1'b1;
                        if (cnt < 3'd3) begin
                            desp <= cnt[1:0];
                            cnt  <= cnt + 3'd1;
                        end else begin
                            desp <= 2'b11;
                            cnt  <= 3'd4;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_teclado_rgb.sv
// Testbench for teclado_rgb: a keypad model drives filas from columnas, the
// stimulus pushes expected strobes into a scoreboard queue and a monitor
// pops and compares whenever pulso or listo is seen.
module tb_teclado_rgb;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;
    localparam int SCAN      = 4 * SCAN_DIV;

    // Key bit positions (4*row+col).
    localparam logic [15:0] M_1 = 16'h0001, M_2 = 16'h0002, M_3 = 16'h0004;
    localparam logic [15:0] M_4 = 16'h0010, M_5 = 16'h0020, M_6 = 16'h0040;
    localparam logic [15:0] M_B = 16'h0080, M_7 = 16'h0100, M_8 = 16'h0200;
    localparam logic [15:0] M_9 = 16'h0400, M_STAR = 16'h1000, M_HASH = 16'h4000;

    typedef struct {
        logic       is_listo;
        logic [4:0] dig;
        logic [1:0] desp;
        logic [1:0] canal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [4:0] digito;
    logic [1:0] desp;
    logic       pulso;
    logic       listo;
    logic [1:0] canal;
    logic [15:0] pressed = '0;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    teclado_rgb #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
        .clk(clk), .rst_n(rst_n), .filas(filas), .columnas(columnas),
        .digito(digito), .desp(desp), .pulso(pulso), .listo(listo), .canal(canal)
    );

    always #5 clk = ~clk;

    // Keypad: a row reads low when a pressed key sits on a driven column.
    assign filas[0] = ~|(pressed[3:0]   & ~columnas);
    assign filas[1] = ~|(pressed[7:4]   & ~columnas);
    assign filas[2] = ~|(pressed[11:8]  & ~columnas);
    assign filas[3] = ~|(pressed[15:12] & ~columnas);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_pulso(input logic [4:0] dig, input logic [1:0] d, input logic [1:0] c);
        exp_t e;
        e.is_listo = 1'b0; e.dig = dig; e.desp = d; e.canal = c;
        q.push_back(e);
    endtask

    task automatic push_listo(input logic [1:0] c);
        exp_t e;
        e.is_listo = 1'b1; e.dig = 5'd0; e.desp = 2'b00; e.canal = c;
        q.push_back(e);
    endtask

    task automatic hold(input logic [15:0] mask, input int scans);
        pressed = mask;
        repeat (scans * SCAN) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] mask, input int on, input int off);
        hold(mask, on);
        hold(16'h0000, off);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_columnas"}, columnas, 4'b1110);
        check({tag, "_digito"},   digito, 5'd16);
        check({tag, "_desp"},     desp, 2'b00);
        check({tag, "_pulso"},    pulso, 1'b0);
        check({tag, "_listo"},    listo, 1'b0);
        check({tag, "_canal"},    canal, 2'b00);
    endtask

    // Scoreboard monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (pulso || listo)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got pulso=%0d listo=%0d digito=%0d desp=%0d, required no strobe",
                         pulso, listo, digito, desp);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {30'd0, pulso, listo}, e.is_listo ? 32'd1 : 32'd2);
                if (!e.is_listo) begin
                    check("digito", digito, e.dig);
                    check("desp", desp, e.desp);
                end
                check("canal", canal, e.canal);
            end
        end
    end

    // Watchdog: the stimulus is bounded, but never let the run hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ec;
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle scan: column rotates every SCAN_DIV clocks, no strobes.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            ec = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check("columnas_rotation", columnas, ec);
        end
        check("idle_digito", digito, 5'd16);
        check("idle_desp", desp, 2'b00);

        // Three digits fill positions 0..2.
        push_pulso(5'd1, 2'b00, 2'b00); press(M_1, 5, 5);
        push_pulso(5'd2, 2'b01, 2'b00); press(M_2, 5, 5);
        push_pulso(5'd3, 2'b10, 2'b00); press(M_3, 5, 5);
        // Fourth digit overflows; '#' at overflow is ignored; '*' clears.
        push_pulso(5'd4, 2'b11, 2'b00); press(M_4, 5, 5);
        press(M_HASH, 5, 5);
        push_pulso(5'd16, 2'b00, 2'b00); press(M_STAR, 5, 5);
        // One digit then enter; then select green.
        push_pulso(5'd7, 2'b00, 2'b00); press(M_7, 5, 5);
        push_listo(2'b00);              press(M_HASH, 5, 5);
        push_pulso(5'd16, 2'b00, 2'b01); press(M_B, 5, 5);
        check("canal_after_b", canal, 2'b01);

        // Bounce: 2 scans on, 1 off, 5 on -> a single emit.
        push_pulso(5'd5, 2'b00, 2'b01);
        hold(M_5, 2);
        hold(16'h0000, 1);
        press(M_5, 5, 5);
        // Two keys together never emit.
        press(M_5 | M_6, 6, 5);
        // Long hold gives one emit only.
        push_pulso(5'd9, 2'b01, 2'b01); press(M_9, 50, 5);

        // Reset while '8' is held: back to reset values, press discarded.
        hold(M_8, 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("midpress_reset");
        rst_n = 1'b1;
        press(M_8, 8, 5);
        push_pulso(5'd8, 2'b00, 2'b00); press(M_8, 5, 5);

        repeat (2 * SCAN) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
